comb_adder_4bit: RTL and testbench

- Unsigned 4-bit ripple-carry adder used as the add path inside the ALU (src/ALU.v).
- Sum and carry-out (OVERFLOW) are purely combinational from IN1/IN2.
- A registered copy of the result (OUT_Q/OVERFLOW_Q) is provided for pipelined ALU users.
- CLK/RESET affect only the registered copy, never the combinational outputs.

---
 rtl/comb_adder_4bit_pkg.sv | 12 +
 rtl/comb_adder_4bit_full_adder.sv | 15 +
 rtl/comb_adder_4bit.sv | 46 ++++
 tb/tb_comb_adder_4bit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/comb_adder_4bit_pkg.sv
// Shared ALU definitions: datapath width and the carry-generation helper
// used by the ripple-carry add path.
package comb_adder_4bit_pkg;

   localparam int ALU_WIDTH = 4;

   // Carry out of a full adder: high when at least two of the three inputs are high.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/comb_adder_4bit_full_adder.sv
// One-bit full adder cell; chained LSB to MSB to form the ripple-carry adder.
module full_adder
   import comb_adder_4bit_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = majority3(a, b, cin);

endmodule

// File: rtl/comb_adder_4bit.sv
// Unsigned ripple-carry adder for the ALU add path, with a registered copy
// of sum and carry-out for pipelined users.
module comb_adder_4bit
   import comb_adder_4bit_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   output logic [WIDTH-1:0] OUT,
   output logic             OVERFLOW,
   input  logic             CLK,
   input  logic             RESET,
   output logic [WIDTH-1:0] OUT_Q,
   output logic             OVERFLOW_Q
);

   logic [WIDTH:0] carryChain;

   // No carry-in port: the chain always starts at zero.
   assign carryChain[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
      full_adder u_fa (
         .a    (IN1[i]),
         .b    (IN2[i]),
         .cin  (carryChain[i]),
         .sum  (OUT[i]),
         .cout (carryChain[i+1])
      );
   end

   assign OVERFLOW = carryChain[WIDTH];

   // Registered copy only; clock and reset never touch the combinational outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         OUT_Q      <= '0;
         OVERFLOW_Q <= 1'b0;
      end else begin
         OUT_Q      <= OUT;
         OVERFLOW_Q <= OVERFLOW;
      end
   end

endmodule

// File: tb/tb_comb_adder_4bit.sv
// Self-checking bench for comb_adder_4bit: exhaustive and random sweeps against
// an integer-arithmetic model, boundary vectors, and the registered path.
module tb_comb_adder_4bit;

   logic       clock;
   logic       reset;
   logic [3:0] in1;
   logic [3:0] in2;
   logic [3:0] out;
   logic       overflow;
   logic [3:0] outQ;
   logic       overflowQ;

   logic [3:0] tiedOut;
   logic       tiedOverflow;
   logic [3:0] tiedOutQ;
   logic       tiedOverflowQ;

   int checkCount = 0;
   int errorCount = 0;

   comb_adder_4bit u_dut (
      .IN1        (in1),
      .IN2        (in2),
      .OUT        (out),
      .OVERFLOW   (overflow),
      .CLK        (clock),
      .RESET      (reset),
      .OUT_Q      (outQ),
      .OVERFLOW_Q (overflowQ)
   );

   // Same adder with clock and reset tied off, as the legacy ALU uses it.
   comb_adder_4bit u_tied (
      .IN1        (in1),
      .IN2        (in2),
      .OUT        (tiedOut),
      .OVERFLOW   (tiedOverflow),
      .CLK        (1'b0),
      .RESET      (1'b0),
      .OUT_Q      (tiedOutQ),
      .OVERFLOW_Q (tiedOverflowQ)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: the exact unsigned sum of two 4-bit operands, as 5 bits.
   function automatic logic [4:0] refSum(input int a, input int b);
      int total;
      total = a + b;
      return total[4:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b expected %b (in1=%0d in2=%0d) at %0t",
                  tag, actual, expected, in1, in2, $time);
      end
   endtask

   task automatic applyStimulus(input string tag, input int a, input int b);
      logic [4:0] expected;
      in1 = a[3:0];
      in2 = b[3:0];
      expected = refSum(a, b);
      #5;
      checkOutput(tag, {3'b000, overflow, out}, {3'b000, expected});
      checkOutput({tag, "Tied"}, {3'b000, tiedOverflow, tiedOut}, {3'b000, expected});
   endtask

   initial begin
      int sweepErrors;
      logic [4:0] expected;
      logic [4:0] held;

      reset = 1'b1;
      in1   = 4'd0;
      in2   = 4'd0;
      #1;
      checkOutput("resetState", {3'b000, overflowQ, outQ}, 8'd0);

      // Exhaustive sweep, one vector every 10 time units, sampled 5 units in.
      sweepErrors = errorCount;
      for (int b = 0; b < 16; b++) begin
         for (int a = 0; a < 16; a++) begin
            applyStimulus("sweep", a, b);
            #5;
         end
      end
      if (errorCount == sweepErrors) $display("[TB] TEST SUCCESSFUL!");
      checkOutput("holdWhileReset", {3'b000, overflowQ, outQ}, 8'd0);

      applyStimulus("zeroPlusZero", 0, 0);
      applyStimulus("wrap15Plus1", 15, 1);
      applyStimulus("max15Plus15", 15, 15);
      applyStimulus("sevenPlusEight", 7, 8);
      applyStimulus("noSignedFlag", 7, 1);
      applyStimulus("eightPlusEight", 8, 8);
      applyStimulus("ninePlusEight", 9, 8);

      // Register latency and hold between edges.
      @(negedge clock);
      reset = 1'b0;
      in1 = 4'd3;
      in2 = 4'd4;
      @(posedge clock);
      #1;
      checkOutput("latencyFirst", {3'b000, overflowQ, outQ}, {3'b000, refSum(3, 4)});
      in1 = 4'd12;
      in2 = 4'd5;
      #3;
      checkOutput("holdBetweenEdges", {3'b000, overflowQ, outQ}, {3'b000, refSum(3, 4)});
      @(posedge clock);
      #1;
      checkOutput("latencySecond", {3'b000, overflowQ, outQ}, {3'b000, refSum(12, 5)});

      // Asynchronous reset mid-cycle, away from any clock edge.
      #1;
      reset = 1'b1;
      #1;
      checkOutput("asyncReset", {3'b000, overflowQ, outQ}, 8'd0);
      checkOutput("combDuringReset", {3'b000, overflow, out}, {3'b000, refSum(12, 5)});
      @(posedge clock);
      #1;
      checkOutput("resetHoldsAcrossEdge", {3'b000, overflowQ, outQ}, 8'd0);

      // Release reset between edges; first capture on the next rising edge.
      @(negedge clock);
      in1 = 4'd10;
      in2 = 4'd10;
      reset = 1'b0;
      #1;
      checkOutput("releaseNoEdge", {3'b000, overflowQ, outQ}, 8'd0);
      @(posedge clock);
      #1;
      checkOutput("releaseCapture", {3'b000, overflowQ, outQ}, {3'b000, refSum(10, 10)});

      // Random vectors through both the combinational and registered paths.
      for (int n = 0; n < 200; n++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         @(negedge clock);
         in1 = a[3:0];
         in2 = b[3:0];
         expected = refSum(a, b);
         #2;
         checkOutput("randomComb", {3'b000, overflow, out}, {3'b000, expected});
         held = expected;
         @(posedge clock);
         #1;
         checkOutput("randomReg", {3'b000, overflowQ, outQ}, {3'b000, held});
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
